// File: rtl/lsc_uart_rx_fifo.sv
// Buffered UART receiver: synchronizer, false-start rejection, framing/parity tagging, FWFT FIFO.
// Optional even parity is enabled by defining LSC_UART_RX_PARITY_EN.
module lsc_uart_rx_fifo #(
  parameter logic [15:0] PERIOD     = 16'd867,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic                  ref_clk,
  input  logic                  resetn,
  input  logic                  i_rxd,
  output logic [7:0]            o_data,
  output logic                  o_ferr,
  output logic                  o_perr,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overrun,
  input  logic                  i_clr
);

  localparam logic [15:0] HALF = PERIOD >> 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;
`ifdef LSC_UART_RX_PARITY_EN
  localparam int EW = 10;
`else
  localparam int EW = 9;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef LSC_UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state;
  logic        rxd_m, rxd_s;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        sample;
  logic        push;
  logic [EW-1:0] push_entry;
`ifdef LSC_UART_RX_PARITY_EN
  logic        perr_q;
`endif

  always_ff @(posedge ref_clk or negedge resetn) begin
    if (!resetn) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= i_rxd;
      rxd_s <= rxd_m;
    end
  end

  assign sample = (cnt == 16'd0);

  always_ff @(posedge ref_clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
`ifdef LSC_UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            state <= S_START;
            cnt   <= HALF;
          end
        end
        S_START: begin
          cnt <= sample ? PERIOD : cnt - 16'd1;
          if (sample) begin
            bit_idx <= 3'd0;
            state   <= rxd_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          cnt <= sample ? PERIOD : cnt - 16'd1;
          if (sample) begin
            shreg   <= {rxd_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef LSC_UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef LSC_UART_RX_PARITY_EN
        S_PARITY: begin
          cnt <= sample ? PERIOD : cnt - 16'd1;
          if (sample) begin
            perr_q <= (^shreg) ^ rxd_s;
            state  <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          cnt <= sample ? PERIOD : cnt - 16'd1;
          if (sample) state <= rxd_s ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          // A held-low line yields one entry; wait for the line to recover.
          if (rxd_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign push = (state == S_STOP) && sample;
`ifdef LSC_UART_RX_PARITY_EN
  assign push_entry = {perr_q, ~rxd_s, shreg};
`else
  assign push_entry = {~rxd_s, shreg};
`endif

  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic [EW-1:0]       mem [DEPTH];
  logic [EW-1:0]       head;
  logic                empty, full, pop, wr_en, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign pop   = !empty && i_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge ref_clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (drop)       o_overrun <= 1'b1;
      else if (i_clr) o_overrun <= 1'b0;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_entry;
  end

  assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign o_valid = !empty;
  assign o_count = wr_ptr - rd_ptr;
  assign o_data  = o_valid ? head[7:0] : 8'd0;
  assign o_ferr  = o_valid & head[8];
`ifdef LSC_UART_RX_PARITY_EN
  assign o_perr  = o_valid & head[9];
`else
  assign o_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_lsc_uart_rx_fifo.sv
// Bench for lsc_uart_rx_fifo: frame driver, queue-based receiver/FIFO model checked every cycle.
module tb_lsc_uart_rx_fifo;
  localparam logic [15:0] P = 16'd15;
  localparam int DL = 4;
  localparam int DEPTH = 16;
  localparam int BT = 16;          // bit time in cycles
  localparam int H = 7;            // half-bit sample point
`ifdef LSC_UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int FB = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int FB = 10;
`endif
  // falling edge driven after edge c0 -> START at c0+3, stop sample at T+H+(FB-1)*BT, visible one edge later
  localparam int PUSH_OFS = 4 + H + (FB - 1) * BT;

  logic          clk, resetn, i_rxd, i_ready, i_clr;
  logic [7:0]    o_data;
  logic          o_ferr, o_perr, o_valid, o_overrun;
  logic [DL:0]   o_count;

  lsc_uart_rx_fifo #(.PERIOD(P), .DEPTH_LOG2(DL)) dut (
    .ref_clk(clk), .resetn(resetn), .i_rxd(i_rxd),
    .o_data(o_data), .o_ferr(o_ferr), .o_perr(o_perr), .o_valid(o_valid),
    .i_ready(i_ready), .o_count(o_count), .o_overrun(o_overrun), .i_clr(i_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: entries are {perr, ferr, data}
  typedef struct { int cyc; logic [9:0] ent; } arr_t;
  arr_t       arr_q[$];
  logic [9:0] exp_q[$];
  logic       m_ovr = 1'b0;
  logic       rdy_q = 1'b0, clr_q = 1'b0;
  int         n_cmp = 0, n_mis = 0;
  int         last_c0 = 0, last_push = 0;
  int         sz;
  logic       pop_m, rej;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      m_ovr = 1'b0;
      rdy_q = 1'b0;
      clr_q = 1'b0;
    end else begin
      sz    = exp_q.size();
      pop_m = (sz > 0) && rdy_q;
      rej   = 1'b0;
      if (pop_m) void'(exp_q.pop_front());
      if (arr_q.size() > 0 && arr_q[0].cyc == cyc) begin
        if (sz < DEPTH || pop_m) exp_q.push_back(arr_q[0].ent);
        else rej = 1'b1;
        void'(arr_q.pop_front());
      end
      if (rej) m_ovr = 1'b1;
      else if (clr_q) m_ovr = 1'b0;
      chk("valid", 32'(o_valid), 32'(exp_q.size() > 0));
      chk("count", 32'(o_count), 32'(exp_q.size()));
      chk("overrun", 32'(o_overrun), 32'(m_ovr));
      if (exp_q.size() > 0) begin
        chk("data", 32'(o_data), 32'(exp_q[0][7:0]));
        chk("ferr", 32'(o_ferr), 32'(exp_q[0][8]));
        chk("perr", 32'(o_perr), 32'(exp_q[0][9]));
      end
      rdy_q = i_ready;
      clr_q = i_clr;
    end
  end

  // driver tasks
  task automatic drive_bit(input logic v);
    i_rxd = v;
    repeat (BT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int low_bits, input bit pforce, input bit pval);
    logic pbit;
    arr_t a;
    @(posedge clk); #1;
    last_c0 = cyc;
    pbit  = pforce ? pval : ^d;
    a.cyc = cyc + PUSH_OFS;
    a.ent = {(PAR_EN ? ((^d) ^ pbit) : 1'b0), (low_bits > 0), d};
    arr_q.push_back(a);
    last_push = a.cyc;
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(d[k]);
    if (PAR_EN) drive_bit(pbit);
    if (low_bits > 0) begin
      i_rxd = 1'b0;
      repeat (low_bits * BT) @(posedge clk);
      #1;
    end
    drive_bit(1'b1);
  endtask

  task automatic drain(input int n);
    @(posedge clk); #1 i_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1 i_ready = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
    n_mis++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  logic [7:0] rb;
  bit         done;

  initial begin
    resetn = 1'b0; i_rxd = 1'b1; i_ready = 1'b0; i_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_overrun", 32'(o_overrun), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_ferr", 32'(o_ferr), 0);
    chk("rst_perr", 32'(o_perr), 0);
    @(posedge clk); #1 resetn = 1'b1;
    repeat (4) @(posedge clk); #1;

    // single byte, consumer always ready
    i_ready = 1'b1;
    fork
      send_frame(8'h55, 0, 1'b0, 1'b0);
      begin
        @(posedge clk); #2;
`ifdef LSC_UART_RX_PARITY_EN
        while (cyc < last_c0 + 3 + 168 - 1) @(negedge clk);
`else
        while (cyc < last_c0 + 3 + 152 - 1) @(negedge clk);
`endif
        chk("single_pre", 32'(o_valid), 0);
        @(negedge clk);
        chk("single_valid", 32'(o_valid), 1);
        chk("single_data", 32'(o_data), 32'h55);
        chk("single_ferr", 32'(o_ferr), 0);
        @(negedge clk);
        chk("single_post", 32'(o_valid), 0);
      end
    join
    i_ready = 1'b0;

    // false start
    @(posedge clk); #1 i_rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1 i_rxd = 1'b1;
    repeat (3 * BT) @(posedge clk);
    @(negedge clk);
    chk("false_valid", 32'(o_valid), 0);
    chk("false_count", 32'(o_count), 0);

    // framing error then clean byte
    send_frame(8'hA3, 3, 1'b0, 1'b0);
    @(negedge clk);
    chk("ferr_count", 32'(o_count), 1);
    chk("ferr_data", 32'(o_data), 32'hA3);
    chk("ferr_flag", 32'(o_ferr), 1);
    send_frame(8'h3C, 0, 1'b0, 1'b0);
    drain(1);
    @(negedge clk);
    chk("ferr_next_data", 32'(o_data), 32'h3C);
    chk("ferr_next_flag", 32'(o_ferr), 0);
    drain(1);

    // overrun
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovr_count", 32'(o_count), 16);
    chk("ovr_flag", 32'(o_overrun), 1);
    @(posedge clk); #1 i_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("drain_data", 32'(o_data), 32'(i));
    end
    @(posedge clk); #1 i_ready = 1'b0;
    @(negedge clk);
    chk("drain_empty", 32'(o_valid), 0);
    @(posedge clk); #1 i_clr = 1'b1;
    @(posedge clk); #1 i_clr = 1'b0;
    @(negedge clk);
    chk("clr_overrun", 32'(o_overrun), 0);

    // full FIFO with a pop in the push cycle
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 0, 1'b0, 1'b0);
    fork
      send_frame(8'h30, 0, 1'b0, 1'b0);
      begin
        @(posedge clk); #2;
        while (cyc != last_push - 1) begin @(posedge clk); #1; end
        i_ready = 1'b1;
        @(posedge clk); #1 i_ready = 1'b0;
        @(negedge clk);
        chk("fwp_count", 32'(o_count), 16);
        chk("fwp_overrun", 32'(o_overrun), 0);
        chk("fwp_head", 32'(o_data), 32'h21);
      end
    join
    drain(20);

`ifdef LSC_UART_RX_PARITY_EN
    send_frame(8'h07, 0, 1'b1, 1'b0);
    send_frame(8'h07, 0, 1'b1, 1'b1);
    @(negedge clk);
    chk("par_bad", 32'(o_perr), 1);
    drain(1);
    @(negedge clk);
    chk("par_good", 32'(o_perr), 0);
    drain(1);
`endif

    // randomized traffic with sparse reads and clears
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          rb = 8'($urandom_range(0, 255));
          send_frame(rb, ($urandom_range(0, 7) == 0) ? 1 : 0,
                     ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          i_ready = ($urandom_range(0, 199) == 0);
          i_clr   = ($urandom_range(0, 299) == 0);
        end
        i_ready = 1'b0;
        i_clr   = 1'b0;
      end
    join

    // reset in the middle of a frame
    @(posedge clk); #1 i_rxd = 1'b0;
    repeat (5 * BT) @(posedge clk);
    #1 resetn = 1'b0; i_rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(o_valid), 0);
    chk("mid_rst_count", 32'(o_count), 0);
    chk("mid_rst_overrun", 32'(o_overrun), 0);
    repeat (3 * BT) @(posedge clk); #1;
    send_frame(8'h5A, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("recover_data", 32'(o_data), 32'h5A);
    chk("recover_count", 32'(o_count), 1);
    drain(20);
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
